// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and bundle layout for pipe_stage_reg and the stage wrappers that pack/unpack bundles.
// Package name: pipe_pkg.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   localparam int CTRL_W_DEF = 10;
   localparam int DATA_W_DEF = 207;

   // ctrl bundle: {RegWrite, MemWrite, ALUSrc, Branch, Jump, ALUControl[2:0], ResultSrc[1:0]}
   localparam int REGWRITE_B = 9;
   localparam int MEMWRITE_B = 8;
   localparam int ALUSRC_B   = 7;
   localparam int BRANCH_B   = 6;
   localparam int JUMP_B     = 5;
   localparam int ALUCTL_LSB = 2;
   localparam int RESSRC_LSB = 0;

   // data bundle: {RD1, RD2, ImmExt, PC, PCPlus4, Instr, Rd, Rs1, Rs2}
   localparam int RD1_LSB     = 175;
   localparam int RD2_LSB     = 143;
   localparam int IMMEXT_LSB  = 111;
   localparam int PC_LSB      = 79;
   localparam int PCPLUS4_LSB = 47;
   localparam int INSTR_LSB   = 15;
   localparam int RD_LSB      = 10;
   localparam int RS1_LSB     = 5;
   localparam int RS2_LSB     = 0;

endpackage

// File: rtl/pipe_stage_reg_perf.sv
// Stall and flush event counters for a pipeline stage; both wrap at 2^32.
// Instantiated by pipe_stage_reg only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic        i_flush_hit,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_cnt
);

   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (i_stall)     r_stall_cnt <= r_stall_cnt + 32'd1;
         if (i_flush_hit) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer so in_ready comes from a flop.
// Optional counters: define PIPE_STAGE_PERF_EN to add stall_cnt/flush_cnt outputs.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W          = CTRL_W_DEF,
   parameter int DATA_W          = DATA_W_DEF,
   parameter bit FLUSH_DATA_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   pipe_state_e       r_state, w_state_nxt;
   logic              r_in_ready;
   logic [CTRL_W-1:0] r_m_ctrl, r_s_ctrl;
   logic [DATA_W-1:0] r_m_data, r_s_data;

   logic w_accept, w_drain, w_m_vld, w_s_vld;
   logic w_ld_m_in, w_ld_m_s, w_ld_s;

   // Entry valid bits are encoded by the state itself.
   assign w_m_vld  = (r_state != EMPTY);
   assign w_s_vld  = (r_state == SKID);
   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = w_m_vld & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != SKID);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_m_in   = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_ld_m_in   = 1'b1;
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (w_accept && w_drain) begin
               w_ld_m_in = 1'b1;
            end else if (w_accept) begin
               w_ld_s      = 1'b1;
               w_state_nxt = SKID;
            end else if (w_drain) begin
               w_state_nxt = EMPTY;
            end
         end
         SKID: begin
            if (w_drain) begin
               w_ld_m_s    = 1'b1;
               w_state_nxt = FULL;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      if (flush) begin
         w_state_nxt = EMPTY;
         w_ld_m_in   = 1'b0;
         w_ld_m_s    = 1'b0;
         w_ld_s      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_ctrl <= '0;
         r_m_data <= '0;
         r_s_ctrl <= '0;
         r_s_data <= '0;
      end else if (flush) begin
         r_m_ctrl <= '0;
         r_s_ctrl <= '0;
         if (FLUSH_DATA_ZERO) begin
            r_m_data <= '0;
            r_s_data <= '0;
         end
      end else begin
         if (w_ld_m_in) begin
            r_m_ctrl <= in_ctrl;
            r_m_data <= in_data;
         end else if (w_ld_m_s) begin
            r_m_ctrl <= r_s_ctrl;
            r_m_data <= r_s_data;
         end
         if (w_ld_s) begin
            r_s_ctrl <= in_ctrl;
            r_s_data <= in_data;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_m_vld;
   // Bubbles must never carry write enables downstream.
   assign out_ctrl  = w_m_vld ? r_m_ctrl : '0;
   assign out_data  = r_m_data;

`ifdef PIPE_STAGE_PERF_EN
   pipe_stage_perf u_perf (
      .clk         (clk),
      .reset       (reset),
      .i_stall     (w_m_vld & ~out_ready),
      .i_flush_hit (flush & (w_m_vld | w_s_vld)),
      .o_stall_cnt (stall_cnt),
      .o_flush_cnt (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: FIFO queue model of occupancy, order, ready and bubble gating.
// Runs both FLUSH_DATA_ZERO settings in parallel; checks counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
   localparam int CW = 10;
   localparam int DW = 207;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, in_ready_b, out_valid_b;
   logic [CW-1:0] out_ctrl, out_ctrl_b;
   logic [DW-1:0] out_data, out_data_b;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   stall_cnt, flush_cnt, stall_cnt_b, flush_cnt_b;
`endif

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;
   ent_t q[$];
   logic pend = 1'b1;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA_ZERO(1'b0)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA_ZERO(1'b1)) dut_z (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_ctrl(out_ctrl_b), .out_data(out_data_b)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [31:0] k);
      logic [223:0] t;
      t = {7{k}};
      return t[DW-1:0];
   endfunction

   task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   // in_ready is held low from reset until the first edge after release
   always @(posedge clk or negedge reset)
      if (!reset) pend <= 1'b1;
      else        pend <= 1'b0;

   always @(negedge clk) begin
      logic exp_rdy, exp_vld, drn, acc;
      if (!reset) begin
         q.delete();
      end else begin
         exp_rdy = !pend && (q.size() < 2);
         exp_vld = (q.size() > 0);
         chk("in_ready", {255'd0, in_ready}, {255'd0, exp_rdy});
         chk("out_valid", {255'd0, out_valid}, {255'd0, exp_vld});
         chk("out_valid_z", {255'd0, out_valid_b}, {255'd0, exp_vld});
         if (exp_vld) begin
            chk("out_ctrl", 256'(out_ctrl), 256'(q[0].c));
            chk("out_data", 256'(out_data), 256'(q[0].d));
         end else begin
            chk("bubble_ctrl", 256'(out_ctrl), 256'd0);
         end
         drn = exp_vld & out_ready;
         acc = in_valid & exp_rdy;
         if (drn) void'(q.pop_front());
         if (flush) q.delete();
         else if (acc) q.push_back('{c: in_ctrl, d: in_data});
      end
   end

   logic [DW-1:0] dead;

   initial begin
      dead = mk(32'hDEAD_BEEF);
      step(0, '0, '0, 0, 0);
      step(0, '0, '0, 0, 0);
      chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
      chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("rst_out_ctrl", 256'(out_ctrl), 256'd0);
      chk("rst_out_data", 256'(out_data), 256'd0);
      reset = 1'b1;
      step(0, '0, '0, 1, 0);
      chk("rel_in_ready", {255'd0, in_ready}, 256'd1);

      // stream A,B,C at full rate
      step(1, 10'h3FF, mk(32'hA), 1, 0);
      step(1, 10'h3FF, mk(32'hB), 1, 0);
      step(1, 10'h3FF, mk(32'hC), 1, 0);
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
      chk("stream_empty", 256'(q.size()), 256'd0);

      // backpressure into SKID, then drain
      step(1, 10'h155, mk(32'h1A), 0, 0);
      step(1, 10'h2AA, mk(32'h1B), 0, 0);
      step(0, '0, '0, 0, 0);
      chk("skid_in_ready", {255'd0, in_ready}, 256'd0);
      chk("skid_head", 256'(out_data), 256'(mk(32'h1A)));
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);

      // flush in SKID with C presented; compare data hold vs zero
      step(1, 10'h0F3, dead, 0, 0);
      step(1, 10'h1C7, mk(32'h2B), 0, 0);
      step(1, 10'h3FF, mk(32'h2C), 0, 1);
      chk("flush_vld", {255'd0, out_valid}, 256'd0);
      chk("flush_ctrl", 256'(out_ctrl), 256'd0);
      chk("flush_rdy", {255'd0, in_ready}, 256'd1);
      chk("flush_data_hold", 256'(out_data), 256'(dead));
      chk("flush_data_zero", 256'(out_data_b), 256'd0);
      step(0, '0, '0, 1, 0);

      // flush in FULL with ready=1: input dropped, drain counts
      step(1, 10'h011, mk(32'h3A), 1, 0);
      step(1, 10'h022, mk(32'h3B), 1, 1);
      step(0, '0, '0, 1, 0);
      chk("flush_full_vld", {255'd0, out_valid}, 256'd0);

      // async reset mid-cycle while FULL
      step(1, 10'h3FF, mk(32'h4A), 0, 0);
      step(0, '0, '0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("async_vld", {255'd0, out_valid}, 256'd0);
      chk("async_ctrl", 256'(out_ctrl), 256'd0);
      chk("async_data", 256'(out_data), 256'd0);
      chk("async_rdy", {255'd0, in_ready}, 256'd0);
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #1;
      chk("async_rel_rdy", {255'd0, in_ready}, 256'd1);

      // stall/flush counter scenario (from fresh reset)
      step(1, 10'h3FF, mk(32'h5A), 0, 0);
      for (int i = 0; i < 5; i++) step(0, '0, '0, 0, 0);
      step(0, '0, '0, 1, 1);
      step(1, 10'h3FF, mk(32'h5B), 0, 0);
      step(0, '0, '0, 1, 1);
      step(0, '0, '0, 0, 1);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", 256'(stall_cnt), 256'd5);
      chk("flush_cnt", 256'(flush_cnt), 256'd2);
      chk("stall_cnt_z", 256'(stall_cnt_b), 256'd5);
`endif
      step(0, '0, '0, 1, 0);
      chk("end_vld", {255'd0, out_valid}, 256'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
